// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, saturation limits and accumulator FSM encoding
package cnn_pkg;

    localparam int IMG_WIDTH_DEF = 16;
    localparam int NUM_WIDTH_DEF = 33;

    localparam logic signed [NUM_WIDTH_DEF-1:0] NUM_MAX = {1'b0, {(NUM_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [NUM_WIDTH_DEF-1:0] NUM_MIN = {1'b1, {(NUM_WIDTH_DEF-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/multiply.sv
// rtl/multiply.sv - registered signed multiplier stage carrying valid/last/bias alongside the product
module multiply
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_val,
    input  logic                         i_last,
    input  logic signed [IMG_WIDTH-1:0]  i_img,
    input  logic signed [IMG_WIDTH-1:0]  i_ker,
    input  logic signed [NUM_WIDTH-1:0]  i_bias,
    output logic                         o_val,
    output logic                         o_last,
    output logic signed [2*IMG_WIDTH-1:0] o_prod,
    output logic signed [NUM_WIDTH-1:0]  o_bias
);

    logic                          r_val;
    logic                          r_last;
    logic signed [2*IMG_WIDTH-1:0] r_prod;
    logic signed [NUM_WIDTH-1:0]   r_bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_last <= 1'b0;
            r_prod <= '0;
            r_bias <= '0;
        end else if (i_en) begin
            r_val  <= i_val;
            r_last <= i_last;
            r_prod <= i_img * i_ker;
            r_bias <= i_bias;
        end
    end

    assign o_val  = r_val;
    assign o_last = r_last;
    assign o_prod = r_prod;
    assign o_bias = r_bias;

endmodule

// File: rtl/accumulate.sv
// rtl/accumulate.sv - bias + sum(img*ker) per window with one-entry output buffer; ACCUMULATE_SATURATE_EN selects clamping
module accumulate
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [NUM_WIDTH-1:0] bias,
    input  logic                        up_val,
    output logic                        up_rdy,
    input  logic signed [IMG_WIDTH-1:0] up_img,
    input  logic signed [IMG_WIDTH-1:0] up_ker,
    input  logic                        up_last,
    output logic                        dn_val,
    input  logic                        dn_rdy,
    output logic signed [NUM_WIDTH-1:0] dn_data,
    output logic                        dn_ovf
);

    logic                          w_en;
    logic                          w_p_val;
    logic                          w_p_last;
    logic signed [2*IMG_WIDTH-1:0] w_p_prod;
    logic signed [NUM_WIDTH-1:0]   w_p_bias;
    logic signed [NUM_WIDTH-1:0]   w_prod_ext;
    logic signed [NUM_WIDTH-1:0]   w_base;
    logic signed [NUM_WIDTH-1:0]   w_result;

    acc_state_t                    r_state;
    logic signed [NUM_WIDTH-1:0]   r_acc;
    logic [15:0]                   r_beat_cnt;
    logic                          r_dn_val;
    logic signed [NUM_WIDTH-1:0]   r_dn_data;

    // Both stages stall together whenever a result is waiting on the consumer.
    assign w_en   = ~r_dn_val | dn_rdy;
    assign up_rdy = w_en;

    multiply #(
        .IMG_WIDTH (IMG_WIDTH),
        .NUM_WIDTH (NUM_WIDTH)
    ) u_multiply (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_val  (up_val),
        .i_last (up_last),
        .i_img  (up_img),
        .i_ker  (up_ker),
        .i_bias (bias),
        .o_val  (w_p_val),
        .o_last (w_p_last),
        .o_prod (w_p_prod),
        .o_bias (w_p_bias)
    );

    assign w_prod_ext = {{(NUM_WIDTH-2*IMG_WIDTH){w_p_prod[2*IMG_WIDTH-1]}}, w_p_prod};
    assign w_base     = (r_state == ST_IDLE) ? w_p_bias : r_acc;

`ifdef ACCUMULATE_SATURATE_EN
    localparam logic signed [NUM_WIDTH-1:0] L_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [NUM_WIDTH-1:0] L_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    logic [NUM_WIDTH:0] w_sum;
    logic               w_add_ovf;
    logic               w_ovf_new;
    logic               r_ovf;
    logic               r_dn_ovf;

    assign w_sum     = {w_base[NUM_WIDTH-1], w_base} + {w_prod_ext[NUM_WIDTH-1], w_prod_ext};
    assign w_add_ovf = w_sum[NUM_WIDTH] ^ w_sum[NUM_WIDTH-1];
    assign w_result  = w_add_ovf ? (w_sum[NUM_WIDTH] ? L_MIN : L_MAX) : w_sum[NUM_WIDTH-1:0];
    // First beat of a window reloads the flag; later beats keep it sticky.
    assign w_ovf_new = w_add_ovf | ((r_state == ST_ACCUM) & r_ovf);
    assign dn_ovf    = r_dn_ovf;
`else
    assign w_result  = w_base + w_prod_ext;
    assign dn_ovf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_dn_val   <= 1'b0;
            r_dn_data  <= '0;
`ifdef ACCUMULATE_SATURATE_EN
            r_ovf      <= 1'b0;
            r_dn_ovf   <= 1'b0;
`endif
        end else if (w_en) begin
            if (dn_rdy) begin
                r_dn_val <= 1'b0;
            end
            if (w_p_val) begin
                r_acc <= w_result;
`ifdef ACCUMULATE_SATURATE_EN
                r_ovf <= w_ovf_new;
`endif
                if (w_p_last) begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                    r_dn_val   <= 1'b1;
                    r_dn_data  <= w_result;
`ifdef ACCUMULATE_SATURATE_EN
                    r_dn_ovf   <= w_ovf_new;
`endif
                end else begin
                    r_state    <= ST_ACCUM;
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
            end
        end
    end

    assign dn_val  = r_dn_val;
    assign dn_data = r_dn_data;

endmodule

// File: tb/tb_accumulate.sv
// tb/tb_accumulate.sv - randomized and directed self-checking bench for accumulate with a window-sum reference model
module tb_accumulate;

    localparam int IW = 16;
    localparam int NW = 33;
    localparam longint MAXV = 64'sd4294967295;
    localparam longint MINV = -64'sd4294967296;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [NW-1:0] bias = '0;
    logic                 up_val = 1'b0;
    logic                 up_rdy;
    logic signed [IW-1:0] up_img = '0;
    logic signed [IW-1:0] up_ker = '0;
    logic                 up_last = 1'b0;
    logic                 dn_val;
    logic                 dn_rdy = 1'b1;
    logic signed [NW-1:0] dn_data;
    logic                 dn_ovf;

    accumulate dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bias    (bias),
        .up_val  (up_val),
        .up_rdy  (up_rdy),
        .up_img  (up_img),
        .up_ker  (up_ker),
        .up_last (up_last),
        .dn_val  (dn_val),
        .dn_rdy  (dn_rdy),
        .dn_data (dn_data),
        .dn_ovf  (dn_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: per-window running sum with plain 64-bit arithmetic.
    longint m_sum;
    bit     m_ovf;
    bit     m_in_win = 1'b0;
    longint exp_d[$];
    bit     exp_o[$];
    longint log_d[$];
    bit     log_o[$];
    logic signed [NW-1:0] held;
    bit     held_v = 1'b0;
    bit     rnd_rdy = 1'b0;

    function automatic longint wrap33(input longint x);
        logic [NW-1:0] t;
        t = x[NW-1:0];
        return longint'($signed(t));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_win = 1'b0;
            exp_d.delete();
            exp_o.delete();
            held_v = 1'b0;
        end else begin
            check("up_rdy_rule", up_rdy, (!dn_val || dn_rdy));
            if (dn_val && held_v) check("held_dn_data", dn_data, held);
            if (dn_val && dn_rdy) begin
                log_d.push_back(longint'(dn_data));
                log_o.push_back(dn_ovf);
                check("result_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) begin
                    check("dn_data", dn_data, exp_d.pop_front());
                    check("dn_ovf", dn_ovf, exp_o.pop_front());
                end
            end
            held_v = dn_val && !dn_rdy;
            held   = dn_data;
            if (up_val && up_rdy) begin
                if (!m_in_win) begin
                    m_sum = longint'(bias);
                    m_ovf = 1'b0;
                end
                m_sum = m_sum + longint'(up_img) * longint'(up_ker);
`ifdef ACCUMULATE_SATURATE_EN
                if (m_sum > MAXV) begin
                    m_sum = MAXV;
                    m_ovf = 1'b1;
                end else if (m_sum < MINV) begin
                    m_sum = MINV;
                    m_ovf = 1'b1;
                end
`else
                m_sum = wrap33(m_sum);
`endif
                if (up_last) begin
                    exp_d.push_back(m_sum);
                    exp_o.push_back(m_ovf);
                    m_in_win = 1'b0;
                end else begin
                    m_in_win = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            dn_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input longint b, input int img, input int ker, input bit last);
        bit ok;
        ok      = 1'b0;
        bias    = b[NW-1:0];
        up_img  = img[IW-1:0];
        up_ker  = ker[IW-1:0];
        up_last = last;
        up_val  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (up_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("beat_accepted", ok, 1);
        @(posedge clk);
        #1;
        up_val  = 1'b0;
        up_last = 1'b0;
    endtask

    task automatic check_log(input int idx, input longint d, input bit o, input string name);
        check({name, "_present"}, log_d.size() > idx, 1);
        if (log_d.size() > idx) begin
            check({name, "_data"}, log_d[idx], d);
            check({name, "_ovf"}, log_o[idx], o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     idx;
        longint t0;
        bit     seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dn_val", dn_val, 0);
        check("reset_dn_data", dn_data, 0);
        check("reset_dn_ovf", dn_ovf, 0);
        check("reset_up_rdy", up_rdy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat window and its two-cycle latency
        send(5, 3, -4, 1);
        @(negedge clk);
        check("lat_c1_dn_val", dn_val, 0);
        @(negedge clk);
        check("lat_c2_dn_val", dn_val, 1);
        check("single_dn_data", dn_data, -7);
        check("single_dn_ovf", dn_ovf, 0);
        @(posedge clk);
        #1;

        // Four-beat window followed back-to-back by a two-beat window
        idx = log_d.size();
        t0  = $time;
        send(0, 1, 1, 0);
        send(0, 2, 2, 0);
        send(0, 3, 3, 0);
        send(0, 4, 4, 1);
        send(10, -1, 5, 0);
        send(0, 2, 2, 1);
        check("b2b_cycles", ($time - t0) / 10, 6);
        repeat (5) @(negedge clk);
        check("b2b_result_count", log_d.size() - idx, 2);
        check_log(idx, 30, 0, "win4");
        check_log(idx + 1, 9, 0, "win2");
        @(posedge clk);
        #1;

        // Back-pressure with a beat waiting upstream
        dn_rdy = 1'b0;
        idx = log_d.size();
        send(1, 2, 3, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dn_val) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_dn_val_seen", seen, 1);
        @(posedge clk);
        #1;
        bias = '0; up_img = 16'sd4; up_ker = 16'sd5; up_last = 1'b1; up_val = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_up_rdy_low", up_rdy, 0);
            check("bp_dn_data_stable", dn_data, 7);
        end
        @(posedge clk);
        #1;
        dn_rdy = 1'b1;
        @(posedge clk);
        #1;
        up_val = 1'b0; up_last = 1'b0;
        repeat (5) @(negedge clk);
        check_log(idx, 7, 0, "bp_first");
        check_log(idx + 1, 20, 0, "bp_second");
        @(posedge clk);
        #1;

        // Overflow boundaries
        idx = log_d.size();
        send(64'sd4294967000, 100, 100, 1);
        send(-64'sd4294967296, -1, 1, 1);
        repeat (5) @(negedge clk);
`ifdef ACCUMULATE_SATURATE_EN
        check_log(idx, 64'sd4294967295, 1, "sat_pos");
        check_log(idx + 1, -64'sd4294967296, 1, "sat_neg");
`else
        check_log(idx, -64'sd4294957592, 0, "wrap_pos");
        check_log(idx + 1, 64'sd4294967295, 0, "wrap_neg");
`endif
        @(posedge clk);
        #1;

        // Reset in the middle of a window discards the partial sum
        send(0, 7, 7, 0);
        send(0, 7, 7, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_dn_val", dn_val, 0);
        check("midreset_up_rdy", up_rdy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idx = log_d.size();
        send(0, 2, 3, 1);
        repeat (5) @(negedge clk);
        check_log(idx, 6, 0, "post_reset");
        @(posedge clk);
        #1;

        // Randomized windows with random back-pressure and idle gaps
        rnd_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            longint rb;
            int     ri;
            int     rk;
            rb = longint'({$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) begin
                ri = -32768;
                rk = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
            end else begin
                ri = int'($urandom());
                rk = int'($urandom());
            end
            send(rb, ri, rk, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send(0, 1, 1, 1);
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        dn_rdy = 1'b1;
        repeat (10) @(negedge clk);
        check("queue_drained", exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulate.md
# accumulate

Multiply-accumulate stage that sits directly upstream of `rescale`. It takes a stream of signed image/kernel operand pairs framed by a last flag and forms `bias + Σ(img·ker)` over each window in a `NUM_WIDTH` accumulator. It presents one signed sum per window through a single-entry, back-pressured output buffer; that sum is the `up_data` consumed by `rescale`.

## Interface
- `IMG_WIDTH`, 16: signed operand width, for both image and kernel.
- `NUM_WIDTH`, 33: signed accumulator and result width; must be ≥ 2·IMG_WIDTH+1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bias`  in  NUM_WIDTH  signed start value; sampled with the first beat of each window.
- `up_val`  in  1  operand beat valid.
- `up_rdy`  out  1  block can accept a beat.
- `up_img`  in  IMG_WIDTH  signed image operand.
- `up_ker`  in  IMG_WIDTH  signed kernel operand.
- `up_last`  in  1  marks the final beat of the window.
- `dn_val`  out  1  result valid.
- `dn_rdy`  in  1  consumer accepts the result.
- `dn_data`  out  NUM_WIDTH  signed window sum.
- `dn_ovf`  out  1  saturation occurred in this window.

## Operation
- Beat transfer: a beat transfers when `up_val & up_rdy`.
- Pipeline enable: `en = ~dn_val | dn_rdy`. `up_rdy = en`. Every pipeline stage advances only when `en` is high.
- Stage 1 (`multiply`): registers the full-width signed product `up_img·up_ker` (2·IMG_WIDTH bits), plus `p_val`, `p_last`, and `bias` sampled on the beat.
- Stage 2, FSM with two states:
  - **IDLE**: on `p_val`, `acc <= bias + sext(product)` and `ovf` is reloaded from this add. Go to ACCUM, or stay in IDLE if `p_last` (single-beat window).
  - **ACCUM**: on `p_val`, `acc <= acc + sext(product)` and `ovf` is sticky-ORed. Return to IDLE on `p_last`.
- Add arithmetic: computed in NUM_WIDTH+1 bits. Overflow is detected when bit NUM_WIDTH differs from bit NUM_WIDTH-1.
- Result: on a `p_val & p_last` update, the final sum and `ovf` load into `dn_data`/`dn_ovf` and `dn_val` sets. `dn_val` clears on `dn_val & dn_rdy` unless a new result loads in the same cycle, in which case it stays set and the data is replaced.
- Beat counter: `beat_cnt` (16 bit) counts beats per window and clears on last. It wraps silently and is for debug visibility only.
- Reset (including mid-window): state goes to IDLE and `acc`, `beat_cnt`, `p_val` and `p_last` clear, so any partial sum is discarded. Output reset values: `dn_val=0`, `dn_data=0`, `dn_ovf=0`, `up_rdy=1`.

## Timing
- Latency: a last beat accepted in cycle c gives `dn_val=1` in cycle c+2.
- Throughput: one beat per cycle while `dn_rdy=1` or no result is pending.
- Back-pressure: when `dn_val & ~dn_rdy`, `up_rdy=0` and both stages hold. No beat is lost or duplicated.
- Consecutive windows: IDLE→IDLE back-to-back is allowed with no bubble. Window N+1's first beat may be accepted in the cycle after window N's last beat.
- `bias` only needs to be stable in the cycle of each window's first beat.

## Configuration
- `ACCUMULATE_SATURATE_EN` defined:
  - On overflow, the add clamps to `2^(NUM_WIDTH-1)-1` (positive overflow) or `-2^(NUM_WIDTH-1)` (negative overflow).
  - `dn_ovf` reports the sticky flag for the window.
  - A clamped accumulator continues accumulating from the clamped value.
- Undefined: the add wraps two's-complement and `dn_ovf` is tied to 0.

## Structure
- Shared package `cnn_pkg` holds:
  - Default `IMG_WIDTH`/`NUM_WIDTH` constants, shared with `rescale`.
  - `NUM_MAX`/`NUM_MIN` saturation constants.
  - The FSM state encoding (`ST_IDLE`, `ST_ACCUM`).
- One sub-module, `multiply`: a registered signed IMG_WIDTH×IMG_WIDTH multiplier with enable, passing valid/last/bias alongside the product.
- Top level holds the FSM, accumulator, counter and output buffer.

## Test plan
All scenarios use the default parameters.
- Single-beat window: bias=5, img=3, ker=−4, last=1, `dn_rdy=1` → `dn_data=−7` in cycle c+2, `dn_ovf=0`.
- Four-beat window: bias=0, pairs (1,1),(2,2),(3,3),(4,4) followed by a back-to-back two-beat window with bias=10, pairs (−1,5),(2,2) → `dn_data=30`, then `dn_data=9`, each with a single `dn_val` pulse and no gap in `up_rdy`.
- Back-pressure: hold `dn_rdy=0` for 5 cycles with a result pending and `up_val` high → `up_rdy=0` throughout, and `dn_data` stays stable. Release `dn_rdy` → the next window completes correctly.
- Saturation (macro defined):
  - bias=4294967000, beat (100,100) → `dn_data=4294967295`, `dn_ovf=1`.
  - bias=−4294967296, beat (−1,1) → `dn_data=−4294967296`, `dn_ovf=1`.
- Wrap (macro undefined): the same positive stimulus gives `dn_data=4294967000+10000−2^33` and `dn_ovf=0`.
- Reset mid-window: after two beats of (7,7), assert `rst_n=0` for 1 cycle → `dn_val=0`, `up_rdy=1`. The next window bias=0, beat (2,3) → `dn_data=6`, with no residue from the discarded beats.
